// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline. Loads and stores go over a req/gnt/rvalid
// data bus with byte lanes and sign/zero extension. Other instructions pass
// straight through. While a bus access is outstanding the stage stalls
// upstream and sends NOP bubbles downstream.
module mem_access_stage #(
    parameter int CTRL_WIDTH    = 16,
    parameter int MEM_READ_BIT  = 0,
    parameter int MEM_WRITE_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [31:0]           alu_out_i,
    input  logic [31:0]           rs2_data_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    input  logic [31:0]           instr_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [31:0]           alu_out_o,
    output logic [31:0]           mem_rdata_o,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic [31:0]           instr_o,
    output logic                  fault_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [31:0]           dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [31:0]           dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [31:0]           dmem_rdata_i
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t                state_q, state_d;

    // Latched copy of the memory instruction being served on the bus
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           instr_q;
    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic [2:0]            funct3_q;

    logic [2:0]            funct3;
    logic                  is_ld, is_st, f3_legal, misaligned, op_fault;
    logic                  capture, pass_done, fault_done, st_done, ld_done;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_data;

    assign funct3  = instr_i[14:12];
    assign stall_o = (state_q != IDLE);

    // Classify the incoming instruction and detect faulting memory accesses.
    // A faulting access never reaches the bus.
    always_comb begin
        // NOTE: every signal in a combinational block gets a default first so no latch is inferred.
        is_ld      = ctrl_i[MEM_READ_BIT];
        is_st      = ctrl_i[MEM_WRITE_BIT];
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        if (is_ld)
            f3_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else
            f3_legal = funct3 inside {3'b000, 3'b001, 3'b010};
        case (funct3[1:0])
            2'b01:   misaligned = alu_out_i[0];
            2'b10:   misaligned = (alu_out_i[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        op_fault = (is_ld && is_st) || ((is_ld || is_st) && (!f3_legal || misaligned));
    end

    // Next-state logic and the completion strobes that steer the output registers
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        pass_done  = 1'b0;
        fault_done = 1'b0;
        st_done    = 1'b0;
        ld_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (op_fault) begin
                        fault_done = 1'b1;
                    end else if (is_ld || is_st) begin
                        capture = 1'b1;
                        state_d = REQ;
                    end else begin
                        pass_done = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    if (ctrl_q[MEM_WRITE_BIT]) begin
                        st_done = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (dmem_rvalid_i) begin
                    ld_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any outstanding transaction
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Capture the memory instruction when it leaves IDLE for the bus
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; they are only read after capture has loaded them.
        if (capture) begin
            addr_q   <= alu_out_i;
            wdata_q  <= rs2_data_i;
            instr_q  <= instr_i;
            ctrl_q   <= ctrl_i;
            funct3_q <= funct3;
        end
    end

    // Drive the data bus from the latched instruction; request only in REQ
    always_comb begin
        dmem_req_o   = (state_q == REQ);
        dmem_we_o    = dmem_req_o && ctrl_q[MEM_WRITE_BIT];
        dmem_addr_o  = {addr_q[31:2], 2'b00};
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = wdata_q;
        if (ctrl_q[MEM_WRITE_BIT]) begin
            case (funct3_q[1:0])
                2'b00: begin
                    dmem_be_o    = 4'b0001 << addr_q[1:0];
                    dmem_wdata_o = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    dmem_be_o    = addr_q[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata_o = {2{wdata_q[15:0]}};
                end
                default: begin
                    dmem_be_o    = 4'b1111;
                    dmem_wdata_o = wdata_q;
                end
            endcase
        end
    end

    // Pick the addressed byte/half out of the read word and extend it
    always_comb begin
        ld_byte = dmem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        ld_half = dmem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    // Output register towards MEM/WB: completed instruction or NOP bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o     <= 1'b0;
            fault_o     <= 1'b0;
            alu_out_o   <= 32'h0;
            mem_rdata_o <= 32'h0;
            ctrl_o      <= '0;
            instr_o     <= NOP;
        end else begin
            valid_o     <= pass_done | fault_done | st_done | ld_done;
            fault_o     <= fault_done;
            mem_rdata_o <= ld_done ? ld_data : 32'h0;
            if (pass_done || fault_done) begin
                alu_out_o <= alu_out_i;
                ctrl_o    <= ctrl_i;
                instr_o   <= instr_i;
            end else if (st_done || ld_done) begin
                alu_out_o <= addr_q;
                ctrl_o    <= ctrl_q;
                instr_o   <= instr_q;
            end else begin
                ctrl_o  <= '0;
                instr_o <= NOP;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios plus randomized traffic
// against a behavioural model of the load/store rules.
module tb_mem_access_stage;

    localparam int          CW  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADD = 32'h0020_81b3;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [31:0]   alu_out_i, rs2_data_i, instr_i;
    logic [CW-1:0] ctrl_i;
    logic          stall_o, valid_o, fault_o;
    logic [31:0]   alu_out_o, mem_rdata_o, instr_o;
    logic [CW-1:0] ctrl_o;
    logic          dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
    logic [31:0]   dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]    dmem_be_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.CTRL_WIDTH(CW), .MEM_READ_BIT(0), .MEM_WRITE_BIT(1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .alu_out_i(alu_out_i),
        .rs2_data_i(rs2_data_i), .ctrl_i(ctrl_i), .instr_i(instr_i),
        .stall_o(stall_o), .valid_o(valid_o), .alu_out_o(alu_out_o),
        .mem_rdata_o(mem_rdata_o), .ctrl_o(ctrl_o), .instr_o(instr_o),
        .fault_o(fault_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
    );

    // ---------------- behavioural reference model ----------------
    function automatic bit ref_fault(bit ld, bit st, logic [2:0] f3, logic [31:0] addr);
        int size;
        if (!ld && !st) return 1'b0;
        if (ld && st) return 1'b1;
        if (st && int'(f3) > 2) return 1'b1;
        if (ld && !(int'(f3) inside {0, 1, 2, 4, 5})) return 1'b1;
        size = 1 << (int'(f3) % 4);
        return (int'(addr[1:0]) % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] word);
        longint nbits, v;
        if (f3 == 3'b010) return word;
        nbits = (f3[1:0] == 2'b00) ? 8 : 16;
        v = (longint'({32'h0, word}) >> (8 * int'(addr[1:0]))) & ((64'sd1 <<< nbits) - 1);
        if (!f3[2] && v >= (64'sd1 <<< (nbits - 1))) v = v - (64'sd1 <<< nbits);
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(bit st, logic [2:0] f3, logic [31:0] addr);
        int off, n;
        logic [3:0] be;
        if (!st) return 4'hF;
        n   = 1 << int'(f3[1:0]);
        off = int'(addr[1:0]);
        be  = '0;
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(logic [2:0] f3, logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   return 32'(rs2[7:0]) * 32'h0101_0101;
            2'b01:   return 32'(rs2[15:0]) * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] mk_instr(logic [6:0] opc, logic [2:0] f3);
        logic [31:0] r;
        r        = $urandom;
        r[6:0]   = opc;
        r[14:12] = f3;
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i       = 1'b0;
        alu_out_i     = 32'h0;
        rs2_data_i    = 32'h0;
        ctrl_i        = '0;
        instr_i       = 32'h0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
    endtask

    // Non-memory op: completes one cycle later with mem_rdata_o = 0
    task automatic run_alu_op(string name, logic [CW-1:0] ctrl, logic [31:0] instr, logic [31:0] alu);
        valid_i = 1'b1; ctrl_i = ctrl; instr_i = instr; alu_out_i = alu; rs2_data_i = $urandom;
        step();
        checks++;
        if ({valid_o, fault_o, stall_o, dmem_req_o} !== 4'b1000) begin
            errors++;
            $display("FAIL %s flags: got valid=%b fault=%b stall=%b req=%b, want 1 0 0 0",
                     name, valid_o, fault_o, stall_o, dmem_req_o);
        end
        checks++;
        if (alu_out_o !== alu || instr_o !== instr || ctrl_o !== ctrl || mem_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL %s data: got alu=%h instr=%h ctrl=%h rdata=%h, want %h %h %h 00000000",
                     name, alu_out_o, instr_o, ctrl_o, mem_rdata_o, alu, instr, ctrl);
        end
    endtask

    // Faulting memory op: no bus access, fault_o/valid_o for one cycle
    task automatic run_fault_op(string name, logic [CW-1:0] ctrl, logic [31:0] instr, logic [31:0] addr);
        valid_i = 1'b1; ctrl_i = ctrl; instr_i = instr; alu_out_i = addr; rs2_data_i = $urandom;
        step();
        valid_i = 1'b0;
        checks++;
        if ({valid_o, fault_o, stall_o, dmem_req_o} !== 4'b1100) begin
            errors++;
            $display("FAIL %s flags: got valid=%b fault=%b stall=%b req=%b, want 1 1 0 0",
                     name, valid_o, fault_o, stall_o, dmem_req_o);
        end
        checks++;
        if (instr_o !== instr || ctrl_o !== ctrl || mem_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL %s data: got instr=%h ctrl=%h rdata=%h, want %h %h 00000000",
                     name, instr_o, ctrl_o, mem_rdata_o, instr, ctrl);
        end
        step();
        checks++;
        if ({valid_o, fault_o, dmem_req_o} !== 3'b000) begin
            errors++;
            $display("FAIL %s after: got valid=%b fault=%b req=%b, want 0 0 0",
                     name, valid_o, fault_o, dmem_req_o);
        end
    endtask

    // Good load/store with scripted gnt and rvalid latency
    task automatic run_mem_op(string name, logic [CW-1:0] ctrl, logic [31:0] instr,
                              logic [31:0] addr, logic [31:0] rs2, int gnt_dly, int rv_dly,
                              logic [31:0] rword, logic [31:0] exp_rdata);
        bit          st;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        st     = ctrl[1];
        exp_be = ref_be(st, instr[14:12], addr);
        exp_wd = ref_wdata(instr[14:12], rs2);
        valid_i = 1'b1; ctrl_i = ctrl; instr_i = instr; alu_out_i = addr; rs2_data_i = rs2;
        step();
        valid_i = 1'b0; ctrl_i = 16'($urandom); instr_i = $urandom;
        alu_out_i = $urandom; rs2_data_i = $urandom;
        for (int k = 0; k <= gnt_dly; k++) begin
            checks++;
            if ({stall_o, valid_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o} !==
                {1'b1, 1'b0, 1'b1, st, addr[31:2], 2'b00, exp_be}) begin
                errors++;
                $display("FAIL %s req cycle %0d: got stall=%b valid=%b req=%b we=%b addr=%h be=%b, want 1 0 1 %b %h %b",
                         name, k, stall_o, valid_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
                         st, {addr[31:2], 2'b00}, exp_be);
            end
            if (st) begin
                checks++;
                if (dmem_wdata_o !== exp_wd) begin
                    errors++;
                    $display("FAIL %s wdata cycle %0d: got %h, want %h", name, k, dmem_wdata_o, exp_wd);
                end
            end
            checks++;
            if (instr_o !== NOP || ctrl_o !== '0) begin
                errors++;
                $display("FAIL %s bubble cycle %0d: got instr=%h ctrl=%h, want %h 0000", name, k, instr_o, ctrl_o, NOP);
            end
            dmem_gnt_i = (k == gnt_dly);
            step();
        end
        dmem_gnt_i = 1'b0;
        if (!st) begin
            for (int k = 1; k <= rv_dly; k++) begin
                checks++;
                if ({stall_o, valid_o, dmem_req_o} !== 3'b100) begin
                    errors++;
                    $display("FAIL %s wait cycle %0d: got stall=%b valid=%b req=%b, want 1 0 0",
                             name, k, stall_o, valid_o, dmem_req_o);
                end
                dmem_rvalid_i = (k == rv_dly);
                dmem_rdata_i  = (k == rv_dly) ? rword : $urandom;
                step();
            end
            dmem_rvalid_i = 1'b0;
        end
        checks++;
        if ({valid_o, fault_o, stall_o, dmem_req_o} !== 4'b1000) begin
            errors++;
            $display("FAIL %s done flags: got valid=%b fault=%b stall=%b req=%b, want 1 0 0 0",
                     name, valid_o, fault_o, stall_o, dmem_req_o);
        end
        checks++;
        if (instr_o !== instr || ctrl_o !== ctrl || alu_out_o !== addr) begin
            errors++;
            $display("FAIL %s done data: got instr=%h ctrl=%h alu=%h, want %h %h %h",
                     name, instr_o, ctrl_o, alu_out_o, instr, ctrl, addr);
        end
        checks++;
        if (mem_rdata_o !== (st ? 32'h0 : exp_rdata)) begin
            errors++;
            $display("FAIL %s rdata: got %h, want %h", name, mem_rdata_o, st ? 32'h0 : exp_rdata);
        end
        step();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s single-cycle valid: got %b, want 0", name, valid_o);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({valid_o, fault_o, stall_o, dmem_req_o, dmem_we_o} !== 5'b0 ||
            alu_out_o !== 32'h0 || mem_rdata_o !== 32'h0 || ctrl_o !== '0 || instr_o !== NOP) begin
            errors++;
            $display("FAIL reset state: got valid=%b fault=%b stall=%b req=%b we=%b alu=%h rdata=%h ctrl=%h instr=%h",
                     valid_o, fault_o, stall_o, dmem_req_o, dmem_we_o, alu_out_o, mem_rdata_o, ctrl_o, instr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        // Put a load into REQ, then reset while the request is pending
        valid_i = 1'b1; ctrl_i = 16'h0001; instr_i = mk_instr(7'h03, 3'b010); alu_out_i = 32'h40;
        step();
        valid_i = 1'b0;
        checks++;
        if (dmem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL reset pre-req: got req=%b, want 1", dmem_req_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dmem_req_o, valid_o, stall_o} !== 3'b000 || instr_o !== NOP) begin
            errors++;
            $display("FAIL reset mid-req: got req=%b valid=%b stall=%b instr=%h, want 0 0 0 %h",
                     dmem_req_o, valid_o, stall_o, instr_o, NOP);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({dmem_req_o, valid_o, stall_o} !== 3'b000) begin
                errors++;
                $display("FAIL reset no-retry cycle %0d: got req=%b valid=%b stall=%b, want 0 0 0",
                         k, dmem_req_o, valid_o, stall_o);
            end
        end
    endtask

    task automatic test_passthrough();
        run_alu_op("pass_add", 16'h0004, ADD, 32'h0000_1234);
        valid_i = 1'b0;
        step();
        checks++;
        if (valid_o !== 1'b0 || instr_o !== NOP) begin
            errors++;
            $display("FAIL pass idle: got valid=%b instr=%h, want 0 %h", valid_o, instr_o, NOP);
        end
    endtask

    task automatic test_store_sb();
        run_mem_op("sb_0x103", 16'h0002, mk_instr(7'h23, 3'b000), 32'h0000_0103,
                   32'hAABB_CCDD, 3, 0, 32'h0, 32'h0);
        run_mem_op("sh_0x102", 16'h0002, mk_instr(7'h23, 3'b001), 32'h0000_0102,
                   32'h1234_5678, 1, 0, 32'h0, 32'h0);
        run_mem_op("sw_0x100", 16'h0002, mk_instr(7'h23, 3'b010), 32'h0000_0100,
                   32'hCAFE_F00D, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_loads();
        run_mem_op("lb_0x2",  16'h0001, mk_instr(7'h03, 3'b000), 32'h2, $urandom, 1, 2, 32'h80FF_7F01, 32'hFFFF_FFFF);
        run_mem_op("lbu_0x3", 16'h0001, mk_instr(7'h03, 3'b100), 32'h3, $urandom, 0, 2, 32'h80FF_7F01, 32'h0000_0080);
        run_mem_op("lh_0x2",  16'h0001, mk_instr(7'h03, 3'b001), 32'h2, $urandom, 2, 2, 32'h80FF_7F01, 32'hFFFF_80FF);
        run_mem_op("lhu_0x0", 16'h0001, mk_instr(7'h03, 3'b101), 32'h0, $urandom, 0, 2, 32'h80FF_7F01, 32'h0000_7F01);
        run_mem_op("lw_0x0",  16'h0001, mk_instr(7'h03, 3'b010), 32'h0, $urandom, 1, 2, 32'h80FF_7F01, 32'h80FF_7F01);
    endtask

    task automatic test_faults();
        run_fault_op("lw_misaligned", 16'h0001, mk_instr(7'h03, 3'b010), 32'h0000_0102);
        run_fault_op("sh_funct3_011", 16'h0002, mk_instr(7'h23, 3'b011), 32'h0000_0100);
        run_fault_op("lh_odd",        16'h0001, mk_instr(7'h03, 3'b001), 32'h0000_0201);
        run_fault_op("ld_and_st",     16'h0003, mk_instr(7'h03, 3'b000), 32'h0000_0000);
    endtask

    task automatic test_stall_hold();
        logic [31:0] ld_instr, word, add_alu;
        int ld_seen, add_seen;
        ld_instr = mk_instr(7'h03, 3'b010);
        word     = $urandom;
        add_alu  = $urandom;
        ld_seen  = 0;
        add_seen = 0;
        valid_i = 1'b1; ctrl_i = 16'h0001; instr_i = ld_instr; alu_out_i = 32'h200;
        step();
        // ADD waits on EX/MEM for the whole load
        ctrl_i = 16'h0004; instr_i = ADD; alu_out_i = add_alu;
        for (int c = 1; c <= 6; c++) begin
            dmem_gnt_i    = (c == 1);
            dmem_rvalid_i = (c == 3);
            dmem_rdata_i  = (c == 3) ? word : $urandom;
            valid_i       = (c <= 4);
            step();
            if (valid_o && instr_o === ld_instr) begin
                ld_seen++;
                checks++;
                if (c != 3 || mem_rdata_o !== word) begin
                    errors++;
                    $display("FAIL hold load: completed cycle %0d rdata=%h, want cycle 3 rdata=%h", c, mem_rdata_o, word);
                end
            end
            if (valid_o && instr_o === ADD) begin
                add_seen++;
                checks++;
                if (c != 4 || alu_out_o !== add_alu || mem_rdata_o !== 32'h0) begin
                    errors++;
                    $display("FAIL hold add: completed cycle %0d alu=%h rdata=%h, want cycle 4 alu=%h rdata=0",
                             c, alu_out_o, mem_rdata_o, add_alu);
                end
            end
            checks++;
            if (stall_o !== (c < 3)) begin
                errors++;
                $display("FAIL hold stall cycle %0d: got %b, want %b", c, stall_o, c < 3);
            end
        end
        checks++;
        if (ld_seen != 1 || add_seen != 1) begin
            errors++;
            $display("FAIL hold count: got load=%0d add=%0d completions, want 1 1", ld_seen, add_seen);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] alu;
        logic [31:0] instr;
        logic [CW-1:0] ctrl;
        for (int i = 0; i < 8; i++) begin
            alu   = $urandom;
            instr = mk_instr(7'h33, 3'($urandom));
            ctrl  = 16'($urandom) & 16'hFFFC;
            run_alu_op("b2b", ctrl, instr, alu);
        end
        valid_i = 1'b0;
        step();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b tail: got valid=%b, want 0", valid_o);
        end
    endtask

    task automatic test_random();
        int          kind, size;
        bit          ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, word, instr;
        logic [CW-1:0] ctrl;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                run_alu_op("rnd_alu", 16'($urandom) & 16'hFFFC, mk_instr(7'h33, 3'($urandom)), $urandom);
                valid_i = 1'b0;
            end else begin
                ld   = (kind < 6) || (kind == 9);
                st   = (kind >= 6);
                f3   = 3'($urandom_range(0, 7));
                addr = $urandom;
                size = 1 << (int'(f3) % 4);
                if ($urandom_range(0, 3) != 0) addr = addr & ~32'(size - 1);
                ctrl    = 16'($urandom) & 16'hFFFC;
                ctrl[0] = ld;
                ctrl[1] = st;
                instr   = mk_instr(ld ? 7'h03 : 7'h23, f3);
                word    = $urandom;
                if (ref_fault(ld, st, f3, addr))
                    run_fault_op("rnd_fault", ctrl, instr, addr);
                else
                    run_mem_op(st ? "rnd_store" : "rnd_load", ctrl, instr, addr, $urandom,
                               $urandom_range(0, 3), $urandom_range(1, 3), word, ref_load(f3, addr, word));
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store_sb();
        test_loads();
        test_faults();
        test_stall_hold();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
